// File: rtl/rr_enc_pkg.sv
// Shared constants and state type for the round-robin request encoder.
package rr_enc_pkg;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  typedef enum logic {IDLE, GRANT} rr_state_t;

endpackage : rr_enc_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping mod N.
module rr_pick
  import rr_enc_pkg::*;
(
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] pick,
  output logic         hit
);

  logic         found;
  logic [W-1:0] pos;

  always_comb begin
    pick  = '0;
    hit   = |req;
    found = 1'b0;
    pos   = '0;
    // W-bit addition wraps the scan position naturally past N-1
    for (int i = 0; i < int'(N); i++) begin
      pos = W'(ptr + W'(i));
      if (!found && req[pos]) begin
        pick  = pos;
        found = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_encoder4.sv
// Round-robin request encoder: registered binary grant index with valid/ready
// handshake and a rotating priority pointer.
module rr_encoder4
  import rr_enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic [W-1:0] idx,
  output logic         valid,
  output logic [N-1:0] grant_oh
);

  rr_state_t    state, state_d;
  logic [W-1:0] ptr, ptr_d;
  logic [W-1:0] idx_d;
  logic         valid_d;
  logic [N-1:0] grant_oh_d;

  logic         hs;
  logic [W-1:0] pick_ptr;
  logic [W-1:0] pick;
  logic         hit;

  // On a handshake the same-cycle pick already starts just past the retiring grant
  assign hs       = valid && ready;
  assign pick_ptr = hs ? W'(idx + W'(1)) : ptr;

  rr_pick u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .pick (pick),
    .hit  (hit)
  );

  // State, pointer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      idx      <= '0;
      valid    <= 1'b0;
      grant_oh <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      idx      <= idx_d;
      valid    <= valid_d;
      grant_oh <= grant_oh_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    idx_d      = idx;
    valid_d    = valid;
    grant_oh_d = grant_oh;

    case (state)
      IDLE: begin
        if (en && hit) begin
          idx_d      = pick;
          grant_oh_d = N'(1) << pick;
          valid_d    = 1'b1;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // Grant is sticky until accepted, even if its request drops
        if (hs) begin
          ptr_d = pick_ptr;
          if (en && hit) begin
            idx_d      = pick;
            grant_oh_d = N'(1) << pick;
          end else begin
            valid_d    = 1'b0;
            grant_oh_d = '0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        valid_d    = 1'b0;
        grant_oh_d = '0;
      end
    endcase
  end

endmodule : rr_encoder4

// File: tb/tb_rr_encoder4.sv
// Scoreboard bench for rr_encoder4: per-cycle expectations from a behavioural model.
module tb_rr_encoder4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       ready;
  logic [3:0] req;
  logic [1:0] idx;
  logic       valid;
  logic [3:0] grant_oh;

  typedef struct packed {
    logic [1:0] idx;
    logic       valid;
    logic [3:0] oh;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_ptr   = 0;
  int m_idx   = 0;
  bit m_valid = 1'b0;

  rr_encoder4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .ready    (ready),
    .idx      (idx),
    .valid    (valid),
    .grant_oh (grant_oh)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (start + k) % 4;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_idx   = 0;
    m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs and push the outputs expected after the next edge
  task automatic step(input bit e, input logic [3:0] r, input bit rd);
    exp_t x;
    @(negedge clk);
    en    = e;
    req   = r;
    ready = rd;
    if (!rst_n) begin
      model_reset();
    end else if (!m_valid) begin
      if (e && r != 4'b0) begin
        m_idx   = first_from(r, m_ptr);
        m_valid = 1'b1;
      end
    end else if (rd) begin
      m_ptr = (m_idx + 1) % 4;
      if (e && r != 4'b0) m_idx = first_from(r, m_ptr);
      else                 m_valid = 1'b0;
    end
    x.idx   = 2'(m_idx);
    x.valid = m_valid;
    x.oh    = m_valid ? 4'(1 << m_idx) : 4'b0;
    exp_q.push_back(x);
  endtask

  // Monitor: compare DUT outputs shortly after each active edge
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("valid", int'(valid), int'(mon_e.valid));
      check("idx", int'(idx), int'(mon_e.idx));
      check("grant_oh", int'(grant_oh), int'(mon_e.oh));
    end
  end

  task automatic sync_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    ready = 1'b0;
    req   = 4'b0;

    // Reset held with active requests
    repeat (3) step(1'b1, 4'b1111, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Full rotation: 0,1,2,3,0
    repeat (5) step(1'b1, 4'b1111, 1'b1);
    // Sparse with wrap: 1,3,1,3
    repeat (4) step(1'b1, 4'b1010, 1'b1);
    step(1'b0, 4'b0000, 1'b1);

    // Backpressure with sticky grant
    repeat (2) step(1'b1, 4'b0100, 1'b0);
    repeat (3) step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 1'b0);

    // Enable gating
    sync_reset();
    repeat (4) step(1'b0, 4'b0001, 1'b1);
    step(1'b1, 4'b0011, 1'b0);
    repeat (3) step(1'b0, 4'b0011, 1'b1);

    // Asynchronous reset pulse between edges while idx=3 is live
    repeat (2) step(1'b1, 4'b1000, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_valid", int'(valid), 0);
    check("async_idx", int'(idx), 0);
    check("async_oh", int'(grant_oh), 0);
    model_reset();
    #1 rst_n = 1'b1;
    step(1'b1, 4'b1001, 1'b1);
    repeat (3) step(1'b1, 4'b1001, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #3;
    check("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rr_encoder4
